// File: rtl/wb_port_arbiter_pkg.sv
// Shared encodings and widths for the register-file write-port arbiter.
// Widths match the register file and the pipeline registers.
package wb_port_arbiter_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_HOLD  = 2'd1,
    ARB_FORCE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the WB stage always wins, and one losing auxiliary
// result is buffered and retried on free slots, requesting a stall if it waits too long.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_regwr,
  input  logic [REG_W-1:0]  wb_wrreg,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              aux_valid,
  input  logic [REG_W-1:0]  aux_wrreg,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              aux_ready,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_req,
  output logic              pend_busy,
  output logic [REG_W-1:0]  pend_reg
);

  localparam logic [CNT_W-1:0] WaitLast = CNT_W'(MAX_WAIT - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [REG_W-1:0]  pend_reg_q, pend_reg_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;

  logic wb_act;
  logic pend_done;

  assign wb_act = wb_regwr && (wb_wrreg != REG_ZERO);
  // Pending result leaves on a free slot (written) or a same-register WB write (WAW discard).
  assign pend_done = !wb_act || (wb_wrreg == pend_reg_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      wait_cnt_q  <= '0;
      pend_reg_q  <= REG_ZERO;
      pend_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      pend_reg_q  <= pend_reg_d;
      pend_data_q <= pend_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    pend_reg_d  = pend_reg_q;
    pend_data_d = pend_data_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (aux_valid && wb_act && (aux_wrreg != REG_ZERO) && (aux_wrreg != wb_wrreg)) begin
          pend_reg_d  = aux_wrreg;
          pend_data_d = aux_wdata;
          wait_cnt_d  = '0;
          state_d     = ARB_HOLD;
        end
      end
      ARB_HOLD, ARB_FORCE: begin
        if (pend_done) begin
          state_d = ARB_IDLE;
        end else begin
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q >= WaitLast) state_d = ARB_FORCE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign aux_ready = (state_q == ARB_IDLE);
  assign pend_busy = (state_q != ARB_IDLE);
  assign stall_req = (state_q == ARB_FORCE);
  assign pend_reg  = pend_reg_q;

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = REG_ZERO;
    rf_wdata = '0;
    if (wb_act) begin
      rf_we    = 1'b1;
      rf_waddr = wb_wrreg;
      rf_wdata = wb_wdata;
    end else if (pend_busy && (pend_reg_q != REG_ZERO) && !reset) begin
      // Held off during reset so a discarded result never reaches the register file.
      rf_we    = 1'b1;
      rf_waddr = pend_reg_q;
      rf_wdata = pend_data_q;
    end else if (aux_ready && aux_valid && (aux_wrreg != REG_ZERO)) begin
      rf_we    = 1'b1;
      rf_waddr = aux_wrreg;
      rf_wdata = aux_wdata;
    end
  end

endmodule
